uart_tx_cfg: RTL and testbench

Parametrised asynchronous serial transmitter, the next generation of the panel UART transmitter. It accepts one character per valid/ready handshake and generates the bit period from a runtime divisor. Word length (5..DATA_W_MAX), parity mode and stop-bit count are runtime-configurable. It sits between the character-pair sequencer and the board TXD/RTS pins, in the 50 MHz system clock domain.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_baud_gen.sv | 26 ++
 rtl/uart_tx_cfg.sv | 173 +++++++++++++++++
 tb/tb_uart_tx_cfg.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the panel UART transmitter and the future receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    localparam int unsigned MIN_WORD_LEN = 5;
    localparam int unsigned MIN_BAUD_DIV = 2;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit timer: counts 0..div-1 and pulses tick on the wrap cycle; clr holds it at 0.
module uart_baud_gen #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    assign tick = !clr && (cnt >= div - DIV_W'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + DIV_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter (word length, parity, stop bits, baud divisor).
// Parity generation is built only when UART_TX_PARITY_EN is defined.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W_MAX = 8,
    parameter int unsigned DIV_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIV_W-1:0]      baud_div,
    input  logic [3:0]            word_len,
    input  logic                  stop2,
    input  logic [1:0]            parity_mode,
    input  logic [DATA_W_MAX-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  txd,
    output logic                  rts,
    output logic                  busy,
    output logic                  done
);

    tx_state_t state, state_nxt;

    logic                  accept;
    logic                  tick;
    logic [3:0]            wlen_c;
    logic [DIV_W-1:0]      div_c;
    logic [DIV_W-1:0]      div_q;
    logic [3:0]            wlen_q;
    logic [3:0]            bit_idx;
    logic                  stop2_q;
    logic                  stop_cnt;
    logic [DATA_W_MAX-1:0] shreg;

    assign tx_ready = (state == IDLE);
    assign busy     = ~tx_ready;
    assign accept   = tx_valid && tx_ready;

    always_comb begin
        wlen_c = word_len;
        if (word_len < 4'(MIN_WORD_LEN)) begin
            wlen_c = 4'(MIN_WORD_LEN);
        end else if (word_len > 4'(DATA_W_MAX)) begin
            wlen_c = 4'(DATA_W_MAX);
        end
    end

    assign div_c = (baud_div < DIV_W'(MIN_BAUD_DIV)) ? DIV_W'(MIN_BAUD_DIV) : baud_div;

`ifdef UART_TX_PARITY_EN
    logic                  par_en_q;
    logic                  par_bit_q;
    logic [DATA_W_MAX-1:0] data_m;

    // Parity covers only the bits that will actually be shifted out.
    always_comb begin
        data_m = '0;
        for (int unsigned i = 0; i < DATA_W_MAX; i++) begin
            if (i < 32'(wlen_c)) begin
                data_m[i] = tx_data[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else if (accept) begin
            par_en_q  <= (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
            par_bit_q <= (^data_m) ^ (parity_mode == PAR_ODD);
        end
    end
`else
    logic unused_parity;
    assign unused_parity = ^parity_mode;
`endif

    uart_baud_gen #(
        .DIV_W (DIV_W)
    ) u_baud (
        .clk  (clk),
        .rst  (rst),
        .clr  (tx_ready),
        .div  (div_q),
        .tick (tick)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q    <= '0;
            wlen_q   <= '0;
            stop2_q  <= 1'b0;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
            shreg    <= '0;
        end else if (accept) begin
            div_q    <= div_c;
            wlen_q   <= wlen_c;
            stop2_q  <= stop2;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
            shreg    <= tx_data;
        end else if (tick) begin
            if (state == DATA) begin
                shreg   <= shreg >> 1;
                bit_idx <= bit_idx + 4'd1;
            end
            if (state == STOP) begin
                stop_cnt <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        txd       = 1'b1;
        rts       = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                rts = 1'b0;
                if (tx_valid) begin
                    state_nxt = START;
                end
            end
            START: begin
                txd = 1'b0;
                if (tick) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                txd = shreg[0];
                if (tick && (bit_idx == wlen_q - 4'd1)) begin
`ifdef UART_TX_PARITY_EN
                    state_nxt = par_en_q ? PARITY : STOP;
`else
                    state_nxt = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                txd = par_bit_q;
                if (tick) begin
                    state_nxt = STOP;
                end
            end
`endif
            STOP: begin
                if (tick && (!stop2_q || stop_cnt)) begin
                    state_nxt = IDLE;
                    done      = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: stimulus pushes expected frames, a negedge monitor checks them.
module tb_uart_tx_cfg;

`ifdef UART_TX_PARITY_EN
    localparam int unsigned PB = 1;
`else
    localparam int unsigned PB = 0;
`endif

    logic        clk;
    logic        rst;
    logic [15:0] baud_div;
    logic [3:0]  word_len;
    logic        stop2;
    logic [1:0]  parity_mode;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        txd;
    logic        rts;
    logic        busy;
    logic        done;

    uart_tx_cfg #(
        .DATA_W_MAX (8),
        .DIV_W      (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .baud_div    (baud_div),
        .word_len    (word_len),
        .stop2       (stop2),
        .parity_mode (parity_mode),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .txd         (txd),
        .rts         (rts),
        .busy        (busy),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] bits;
        int unsigned nbits;
        int unsigned div;
        int unsigned clks;
        int unsigned gap;
        bit          abort;
        logic [1:0]  pm;
    } frame_t;

    frame_t sb[$];
    int checks = 0;
    int fails  = 0;
    int done_total = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic frame_t mk(input logic [7:0] data, input int unsigned div,
                                  input int unsigned wl, input logic s2, input logic [1:0] pm,
                                  input int unsigned clks, input int unsigned gap, input bit abort);
        frame_t      f;
        int unsigned w;
        int unsigned n;
        logic        p;
        w = (wl < 5) ? 5 : ((wl > 8) ? 8 : wl);
        f.bits = '1;
        f.bits[0] = 1'b0;
        n = 1;
        p = 1'b0;
        for (int unsigned i = 0; i < w; i++) begin
            f.bits[n] = data[i];
            p = p ^ data[i];
            n++;
        end
`ifdef UART_TX_PARITY_EN
        if (pm == 2'b01 || pm == 2'b10) begin
            f.bits[n] = (pm == 2'b10) ? ~p : p;
            n++;
        end
`endif
        n = n + (s2 ? 2 : 1);
        f.nbits = n;
        f.div   = (div < 2) ? 2 : div;
        f.clks  = clks;
        f.gap   = gap;
        f.abort = abort;
        f.pm    = pm;
        return f;
    endfunction

    // Monitor: frame boundaries are taken from rts; every cycle of the frame is checked.
    initial begin : monitor
        frame_t      cur;
        bit          in_frame;
        int unsigned k;
        int unsigned errs;
        int unsigned flag_errs;
        int unsigned dones;
        int          done_k;
        int unsigned idle_cnt;
        int unsigned bi;
        logic        exp_b;
        in_frame = 0;
        idle_cnt = 0;
        k = 0; errs = 0; flag_errs = 0; dones = 0; done_k = -1;
        cur = mk(8'h00, 2, 8, 1'b0, 2'b00, 0, 0, 1'b1);
        forever begin
            @(negedge clk);
            if (done) done_total++;
            if (!in_frame && rts) begin
                if (sb.size() == 0) begin
                    check("unexpected_frame", 1, 0);
                    cur = mk(8'h00, 2, 8, 1'b0, 2'b00, 0, 0, 1'b1);
                end else begin
                    cur = sb.pop_front();
                    if (cur.gap != 0) check("frame_gap", idle_cnt, cur.gap);
                end
                in_frame = 1;
                k = 0; errs = 0; flag_errs = 0; dones = 0; done_k = -1;
            end
            if (in_frame) begin
                if (rts) begin
                    bi = k / cur.div;
                    exp_b = (bi < cur.nbits) ? cur.bits[bi] : 1'b1;
                    if (txd !== exp_b) errs++;
                    if (tx_ready !== 1'b0 || busy !== 1'b1) flag_errs++;
                    if (done === 1'b1) begin
                        dones++;
                        done_k = int'(k);
                    end
                    k++;
                end else begin
                    check("txd_wave", errs, 0);
                    check("busy_flags", flag_errs, 0);
                    check("idle_txd", txd, 1);
                    if (cur.abort) begin
                        check("abort_no_done", dones, 0);
                    end else begin
                        check("frame_len", k, cur.clks);
                        check("done_count", dones, 1);
                        check("done_pos", done_k, int'(cur.clks) - 1);
                    end
                    in_frame = 0;
                    idle_cnt = 1;
                end
            end else begin
                idle_cnt++;
            end
        end
    end

    task automatic wait_ready();
        int unsigned n;
        n = 0;
        while (tx_ready !== 1'b1 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (tx_ready !== 1'b1) check("ready_timeout", 0, 1);
    endtask

    // Presents one character; returns 1 time unit after the accepting edge.
    task automatic send(input logic [7:0] data, input logic [15:0] div, input logic [3:0] wl,
                        input logic s2, input logic [1:0] pm, input int unsigned clks, input bit abort);
        wait_ready();
        baud_div    = div;
        word_len    = wl;
        stop2       = s2;
        parity_mode = pm;
        tx_data     = data;
        sb.push_back(mk(data, div, wl, s2, pm, clks, 0, abort));
        tx_valid    = 1'b1;
        @(posedge clk);
        #1;
        tx_valid    = 1'b0;
    endtask

    initial begin : stim
        rst = 1'b0;
        baud_div = 16'd4;
        word_len = 4'd8;
        stop2 = 1'b0;
        parity_mode = 2'b00;
        tx_data = 8'h00;
        tx_valid = 1'b0;

        #2;
        check("rst_txd", txd, 1);
        check("rst_rts", rts, 0);
        check("rst_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_ready", tx_ready, 1);
        check("post_rst_txd", txd, 1);

        // Frame timing; tx_valid pulsed mid-frame must be ignored.
        send(8'hA5, 16'd4, 4'd8, 1'b0, 2'b00, 40, 1'b0);
        check("start_latency_txd", txd, 0);
        check("start_rts", rts, 1);
        repeat (5) @(posedge clk);
        #1 tx_valid = 1'b1;
        repeat (5) @(posedge clk);
        #1 tx_valid = 1'b0;

        // Parity even/odd on 7 ones.
        send(8'h7F, 16'd2, 4'd7, 1'b0, 2'b01, 18 + 2 * PB, 1'b0);
        send(8'h7F, 16'd2, 4'd7, 1'b0, 2'b10, 18 + 2 * PB, 1'b0);

        // word_len 3 -> 5, baud_div 0 -> 2, two stop bits.
        send(8'hF5, 16'd0, 4'd3, 1'b1, 2'b00, 16, 1'b0);
        // word_len 15 -> 8, parity_mode 11 = none.
        send(8'h3C, 16'd3, 4'd15, 1'b0, 2'b11, 30, 1'b0);

        // Back-to-back with tx_valid held.
        wait_ready();
        baud_div = 16'd2; word_len = 4'd8; stop2 = 1'b0; parity_mode = 2'b00;
        tx_data = 8'h00;
        sb.push_back(mk(8'h00, 2, 8, 1'b0, 2'b00, 20, 0, 1'b0));
        sb.push_back(mk(8'hFF, 2, 8, 1'b0, 2'b00, 20, 1, 1'b0));
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_data = 8'hFF;
        wait_ready();
        @(posedge clk);
        #1 tx_valid = 1'b0;

        // Mid-frame reset during DATA.
        send(8'h55, 16'd4, 4'd8, 1'b0, 2'b00, 40, 1'b1);
        repeat (14) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("async_rst_txd", txd, 1);
        check("async_rst_rts", rts, 0);
        check("async_rst_done", done, 0);
        check("async_rst_ready", tx_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("rel_rst_ready", tx_ready, 1);
        send(8'hC3, 16'd2, 4'd8, 1'b0, 2'b00, 20, 1'b0);

        // Config changes after accept must not disturb the frame in flight.
        send(8'h96, 16'd3, 4'd6, 1'b0, 2'b00, 24, 1'b0);
        baud_div = 16'd5; word_len = 4'd8; stop2 = 1'b1; parity_mode = 2'b01; tx_data = 8'h00;
        send(8'h81, 16'd5, 4'd8, 1'b1, 2'b01, 55 + 5 * PB, 1'b0);

        wait_ready();
        repeat (4) @(posedge clk);
        #1;
        check("sb_empty", sb.size(), 0);
        check("done_total", done_total, 10);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        fails++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $fatal(1, "watchdog");
    end

endmodule
